// File: rtl/perf_snapshot_fifo_apb.sv
// Snapshot FIFO of perf counters with a zero-wait APB read/pop port; a push is visible one cycle later.
// No backpressure: a push into a full FIFO is dropped and counted. Optional macro PERF_SNAP_TIMESTAMP_EN.
module perf_snapshot_fifo_apb #(
    parameter int Depth        = 4,
    parameter int CntWidth     = 64,
    parameter int DropCntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                snap_valid_i,
    input  logic [CntWidth-1:0] snap_runtime_i,
    input  logic [CntWidth-1:0] snap_dcache_i,
    input  logic [CntWidth-1:0] snap_icache_i,
    input  logic [CntWidth-1:0] snap_sbfull_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [31:0]         paddr_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    output logic                nonempty_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h04;
    localparam logic [7:0] ADDR_RT_LO   = 8'h08;
    localparam logic [7:0] ADDR_RT_HI   = 8'h0C;
    localparam logic [7:0] ADDR_DC_LO   = 8'h10;
    localparam logic [7:0] ADDR_DC_HI   = 8'h14;
    localparam logic [7:0] ADDR_IC_LO   = 8'h18;
    localparam logic [7:0] ADDR_IC_HI   = 8'h1C;
    localparam logic [7:0] ADDR_SB_LO   = 8'h20;
    localparam logic [7:0] ADDR_SB_HI   = 8'h24;
    localparam logic [7:0] ADDR_DROPPED = 8'h28;
    localparam logic [7:0] ADDR_TS_LO   = 8'h30;
    localparam logic [7:0] ADDR_TS_HI   = 8'h34;

    logic [PtrW-1:0]         wr_ptr, rd_ptr;
    logic [CntW-1:0]         count, count_nxt;
    logic                    ovf_q;
    logic [DropCntWidth-1:0] drop_cnt;
    logic                    empty, full;

    logic [CntWidth-1:0] mem_rt [Depth];
    logic [CntWidth-1:0] mem_dc [Depth];
    logic [CntWidth-1:0] mem_ic [Depth];
    logic [CntWidth-1:0] mem_sb [Depth];

    logic        access, ctrl_wr, do_flush, do_pop, do_clr, push_ok, ovf_evt;
    logic [7:0]  addr;
    logic [31:0] rd_data;
    logic        dec_err;
    logic [63:0] head_rt, head_dc, head_ic, head_sb, head_ts;
    logic        unused_bits;

    assign unused_bits = ^{paddr_i[31:8], pwdata_i[31:3]};

    assign addr     = paddr_i[7:0];
    assign access   = psel_i & penable_i;
    assign empty    = (count == '0);
    assign full     = (count == CntW'(Depth));
    assign ctrl_wr  = access & pwrite_i & (addr == ADDR_CTRL);
    assign do_flush = ctrl_wr & pwdata_i[2];
    assign do_pop   = ctrl_wr & pwdata_i[0] & ~empty & ~do_flush;
    assign do_clr   = ctrl_wr & pwdata_i[1];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
    assign push_ok  = snap_valid_i & ~do_flush & (~full | do_pop);
    assign ovf_evt  = snap_valid_i & ~do_flush & full & ~do_pop;

    always_comb begin
        count_nxt = count;
        if (do_flush) begin
            count_nxt = '0;
        end else if (push_ok && !do_pop) begin
            count_nxt = count + CntW'(1);
        end else if (do_pop && !push_ok) begin
            count_nxt = count - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt   <= '0;
            nonempty_o <= 1'b0;
        end else begin
            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            end
            count      <= count_nxt;
            nonempty_o <= (count_nxt != '0);
            // A same-cycle overflow outranks a software clear.
            if (ovf_evt)     ovf_q <= 1'b1;
            else if (do_clr) ovf_q <= 1'b0;
            if (ovf_evt && drop_cnt != '1) drop_cnt <= drop_cnt + DropCntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_rt[wr_ptr] <= snap_runtime_i;
            mem_dc[wr_ptr] <= snap_dcache_i;
            mem_ic[wr_ptr] <= snap_icache_i;
            mem_sb[wr_ptr] <= snap_sbfull_i;
        end
    end

    assign head_rt = empty ? 64'd0 : 64'(mem_rt[rd_ptr]);
    assign head_dc = empty ? 64'd0 : 64'(mem_dc[rd_ptr]);
    assign head_ic = empty ? 64'd0 : 64'(mem_ic[rd_ptr]);
    assign head_sb = empty ? 64'd0 : 64'(mem_sb[rd_ptr]);

`ifdef PERF_SNAP_TIMESTAMP_EN
    logic [63:0] ts_q;
    logic [63:0] mem_ts [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= 64'd0;
        else         ts_q <= ts_q + 64'd1;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_ts[wr_ptr] <= ts_q;
    end

    assign head_ts = empty ? 64'd0 : mem_ts[rd_ptr];
`else
    assign head_ts = 64'd0;
`endif

    always_comb begin
        rd_data = 32'd0;
        dec_err = pwrite_i;
        unique case (addr)
            ADDR_STATUS:  rd_data = 32'({ovf_q, full, empty, 8'(count)});
            ADDR_CTRL:    dec_err = 1'b0;
            ADDR_RT_LO:   rd_data = head_rt[31:0];
            ADDR_RT_HI:   rd_data = head_rt[63:32];
            ADDR_DC_LO:   rd_data = head_dc[31:0];
            ADDR_DC_HI:   rd_data = head_dc[63:32];
            ADDR_IC_LO:   rd_data = head_ic[31:0];
            ADDR_IC_HI:   rd_data = head_ic[63:32];
            ADDR_SB_LO:   rd_data = head_sb[31:0];
            ADDR_SB_HI:   rd_data = head_sb[63:32];
            ADDR_DROPPED: rd_data = 32'(drop_cnt);
            ADDR_TS_LO:   rd_data = head_ts[31:0];
            ADDR_TS_HI:   rd_data = head_ts[63:32];
            default:      dec_err = 1'b1;
        endcase
    end

    assign pready_o  = access;
    assign pslverr_o = access & dec_err;
    assign prdata_o  = (access && !pwrite_i) ? rd_data : 32'd0;

endmodule

// File: tb/tb_perf_snapshot_fifo_apb.sv
// Randomized bench for perf_snapshot_fifo_apb against a queue-based model of the snapshot FIFO.
module tb_perf_snapshot_fifo_apb;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] rt;
        logic [63:0] dc;
        logic [63:0] ic;
        logic [63:0] sb;
        logic [63:0] ts;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snap_valid = 1'b0;
    logic [63:0] snap_rt = '0, snap_dc = '0, snap_ic = '0, snap_sb = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, nonempty;

    int errors = 0;
    int checks = 0;

    snap_t       q[$];
    logic        m_ovf = 1'b0;
    int          m_drops = 0;
    logic [63:0] tb_cyc;

    perf_snapshot_fifo_apb #(.Depth(DEPTH), .CntWidth(64), .DropCntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .snap_valid_i(snap_valid),
        .snap_runtime_i(snap_rt), .snap_dcache_i(snap_dc),
        .snap_icache_i(snap_ic), .snap_sbfull_i(snap_sb),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr), .nonempty_o(nonempty)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release: the value a snapshot's timestamp should carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 64'd0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    function automatic logic [31:0] exp_status();
        return {21'd0, m_ovf, (q.size() == DEPTH), (q.size() == 0), 8'(q.size())};
    endfunction

    function automatic logic [31:0] exp_reg(input logic [7:0] a);
        snap_t h;
        if (a == 8'h00) return exp_status();
        if (a == 8'h28) return 32'(m_drops);
        if (q.size() == 0) return 32'd0;
        h = q[0];
        case (a)
            8'h08: return h.rt[31:0];
            8'h0C: return h.rt[63:32];
            8'h10: return h.dc[31:0];
            8'h14: return h.dc[63:32];
            8'h18: return h.ic[31:0];
            8'h1C: return h.ic[63:32];
            8'h20: return h.sb[31:0];
            8'h24: return h.sb[63:32];
`ifdef PERF_SNAP_TIMESTAMP_EN
            8'h30: return h.ts[31:0];
            8'h34: return h.ts[63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic snap_t rand_snap(input logic [63:0] rt);
        snap_t s;
        s.rt = rt;
        s.dc = {$urandom, $urandom};
        s.ic = {$urandom, $urandom};
        s.sb = {$urandom, $urandom};
        s.ts = '0;
        return s;
    endfunction

    // One clock edge of the model: clear, then flush or pop-then-push.
    task automatic model_step(input logic ctrl, input logic [31:0] wd, input logic push, input snap_t s);
        if (ctrl && wd[1]) m_ovf = 1'b0;
        if (ctrl && wd[2]) begin
            q.delete();
        end else begin
            if (ctrl && wd[0] && q.size() > 0) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(s);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    endtask

    task automatic drive_snap(input snap_t s);
        snap_valid = 1'b1;
        snap_rt = s.rt; snap_dc = s.dc; snap_ic = s.ic; snap_sb = s.sb;
    endtask

    task automatic bus_op(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          input logic push, input snap_t s_in,
                          output logic [31:0] rd, output logic err);
        snap_t s;
        s = s_in;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {24'hABCDEF, a}; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        if (push) begin
            s.ts = tb_cyc;
            drive_snap(s);
        end
        #2;
        rd = prdata;
        err = pslverr;
        model_step(wr && a == 8'h04, wd, push, s);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; snap_valid = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] d, output logic e);
        bus_op(1'b0, a, 32'd0, 1'b0, '0, d, e);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] wd, output logic e);
        logic [31:0] d;
        bus_op(1'b1, a, wd, 1'b0, '0, d, e);
    endtask

    task automatic push_snap(input snap_t s_in);
        snap_t s;
        s = s_in;
        @(negedge clk);
        s.ts = tb_cyc;
        drive_snap(s);
        model_step(1'b0, 32'd0, 1'b1, s);
        @(negedge clk);
        snap_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete(); m_ovf = 1'b0; m_drops = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        checks++;
        if (prdata !== 32'd0 || pready !== 1'b0 || pslverr !== 1'b0 || nonempty !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got prdata=%h pready=%b pslverr=%b nonempty=%b, want all 0",
                     prdata, pready, pslverr, nonempty);
        end
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h100 || e !== 1'b0) begin
            errors++; $display("FAIL reset_status: got %h err=%b, want 100 err=0", d, e);
        end
        rd_reg(8'h08, d, e);
        checks++;
        if (d !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL empty_data_read: got %h err=%b, want 0 err=0", d, e);
        end
    endtask

    task automatic test_single_push();
        logic [31:0] d; logic e; snap_t s;
        s = rand_snap(64'h1_0000_0005);
        s.dc = 64'd3;
        push_snap(s);
        checks++;
        if (nonempty !== 1'b1) begin
            errors++; $display("FAIL nonempty_rise: got %b, want 1", nonempty);
        end
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h001) begin errors++; $display("FAIL single_status: got %h, want 001", d); end
        rd_reg(8'h08, d, e);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL single_rt_lo: got %h, want 5", d); end
        rd_reg(8'h0C, d, e);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL single_rt_hi: got %h, want 1", d); end
        rd_reg(8'h10, d, e);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL single_dc_lo: got %h, want 3", d); end
        wr_reg(8'h04, 32'h1, e);
        checks++;
        if (nonempty !== 1'b0 || e !== 1'b0) begin
            errors++; $display("FAIL nonempty_fall: got nonempty=%b err=%b, want 0 0", nonempty, e);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic e;
        for (int i = 0; i < 5; i++) push_snap(rand_snap(64'(10 + i)));
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h604) begin errors++; $display("FAIL ovf_status: got %h, want 604", d); end
        rd_reg(8'h28, d, e);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL dropped: got %0d, want 1", d); end
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 8; r++) begin
                logic [7:0] a;
                a = 8'(8 + 4 * r);
                rd_reg(a, d, e);
                checks++;
                if (d !== exp_reg(a) || e !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_pop%0d_reg%h: got %h err=%b, want %h", i, a, d, e, exp_reg(a));
                end
            end
            checks++;
            if (q[0].rt !== 64'(10 + i)) begin
                errors++; $display("FAIL drain_order%0d: model head %0d, want %0d", i, q[0].rt, 10 + i);
            end
            wr_reg(8'h04, 32'h1, e);
        end
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h500) begin errors++; $display("FAIL drained_status: got %h, want 500", d); end
        wr_reg(8'h04, 32'h1, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL pop_empty_err: got %b, want 0", e); end
        wr_reg(8'h04, 32'h2, e);
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL ovf_clear: got %h, want 100", d); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d; logic e;
        for (int i = 0; i < 4; i++) push_snap(rand_snap({$urandom, $urandom}));
        bus_op(1'b1, 8'h04, 32'h1, 1'b1, rand_snap(64'hDEAD_0000_BEEF), d, e);
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h204 || d !== exp_status()) begin
            errors++; $display("FAIL full_push_pop_status: got %h, want 204", d);
        end
        rd_reg(8'h08, d, e);
        checks++;
        if (d !== exp_reg(8'h08)) begin
            errors++; $display("FAIL full_push_pop_head: got %h, want %h", d, exp_reg(8'h08));
        end
        bus_op(1'b1, 8'h04, 32'h2, 1'b1, rand_snap(64'd77), d, e);
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h604) begin errors++; $display("FAIL clr_vs_ovf: got %h, want 604", d); end
        wr_reg(8'h04, 32'h2, e);
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h204) begin errors++; $display("FAIL clr_alone: got %h, want 204", d); end
    endtask

    task automatic test_errors_flush();
        logic [31:0] d, st; logic e;
        wr_reg(8'h04, 32'h4, e);
        for (int i = 0; i < 3; i++) push_snap(rand_snap({$urandom, $urandom}));
        st = exp_status();
        wr_reg(8'h38, 32'h7, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_wr38: got %b, want 1", e); end
        rd_reg(8'h40, d, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_rd40: got %b, want 1", e); end
        wr_reg(8'h00, 32'hFFFF_FFFF, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_wr_status: got %b, want 1", e); end
        rd_reg(8'h2C, d, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_rd2c: got %b, want 1", e); end
        rd_reg(8'h04, d, e);
        checks++;
        if (d !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL ctrl_read: got %h err=%b, want 0 err=0", d, e);
        end
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== st || d !== 32'h003) begin errors++; $display("FAIL err_no_effect: got %h, want 003", d); end
        bus_op(1'b1, 8'h04, 32'h5, 1'b1, rand_snap(64'd9), d, e);
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL flush_status: got %h, want 100", d); end
    endtask

    task automatic test_timestamp();
        logic [31:0] d; logic e; logic [63:0] want;
        do_reset();
        repeat (3) @(negedge clk);
        push_snap(rand_snap(64'd1));
        want = q[0].ts;
        rd_reg(8'h30, d, e);
        checks++;
`ifdef PERF_SNAP_TIMESTAMP_EN
        if (d !== want[31:0] || e !== 1'b0) begin
            errors++; $display("FAIL ts_lo: got %h err=%b, want %h", d, e, want[31:0]);
        end
`else
        if (d !== 32'd0 || e !== 1'b0 || want == 64'd0) begin
            errors++; $display("FAIL ts_lo_off: got %h err=%b, want 0 err=0", d, e);
        end
`endif
        rd_reg(8'h34, d, e);
        checks++;
        if (d !== exp_reg(8'h34) || e !== 1'b0) begin
            errors++; $display("FAIL ts_hi: got %h err=%b, want %h", d, e, exp_reg(8'h34));
        end
    endtask

    task automatic test_random();
        logic [31:0] d; logic e;
        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: push_snap(rand_snap({$urandom, $urandom}));
                4, 5:       wr_reg(8'h04, 32'h1, e);
                6:          bus_op(1'b1, 8'h04, 32'h1, 1'b1, rand_snap({$urandom, $urandom}), d, e);
                7: begin
                    logic [7:0] a;
                    a = 8'(8 + 4 * $urandom_range(0, 7));
                    rd_reg(a, d, e);
                    checks++;
                    if (d !== exp_reg(a)) begin
                        errors++; $display("FAIL rand_reg%h_%0d: got %h, want %h", a, i, d, exp_reg(a));
                    end
                end
                8:  wr_reg(8'h04, ($urandom_range(0, 3) == 0) ? 32'h4 : 32'h2, e);
                default: bus_op(1'b1, 8'h04, 32'h2, 1'b1, rand_snap({$urandom, $urandom}), d, e);
            endcase
            rd_reg(8'h00, d, e);
            checks++;
            if (d !== exp_status()) begin
                errors++; $display("FAIL rand_status_%0d: got %h, want %h", i, d, exp_status());
            end
            checks++;
            if (nonempty !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_nonempty_%0d: got %b, want %b", i, nonempty, q.size() != 0);
            end
        end
        rd_reg(8'h28, d, e);
        checks++;
        if (d !== 32'(m_drops)) begin errors++; $display("FAIL rand_dropped: got %0d, want %0d", d, m_drops); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic e;
        for (int i = 0; i < 2; i++) push_snap(rand_snap({$urandom, $urandom}));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (nonempty !== 1'b0) begin errors++; $display("FAIL async_reset_nonempty: got %b, want 0", nonempty); end
        q.delete(); m_ovf = 1'b0; m_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(8'h00, d, e);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL async_reset_status: got %h, want 100", d); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_push();
        test_overflow();
        test_push_pop_full();
        test_errors_flush();
        test_timestamp();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perf_snapshot_fifo_apb.md
Name: perf_snapshot_fifo_apb

Overview:
- Downstream consumer of the testbench vector-runtime/perf-counter update logic. On each "runtime buffer updated" event it captures one snapshot of runtime, D$ stall, I$ stall and scoreboard-full counts.
- Snapshots go into a small FIFO, so software running several benchmarks per program can read every result, not only the last.
- Software reads and pops snapshots through an APB slave on the same bus as the mock UART.

Parameters:
- Depth, 4, number of snapshot entries; power of two, ≥2.
- CntWidth, 64, width of each captured counter.
- DropCntWidth, 16, width of the saturating dropped-snapshot counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- snap_valid_i  in  1  one-cycle capture pulse (runtime buffer update event)
- snap_runtime_i  in  CntWidth  vector runtime count
- snap_dcache_i  in  CntWidth  D$ stall count
- snap_icache_i  in  CntWidth  I$ stall count
- snap_sbfull_i  in  CntWidth  scoreboard-full count
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- paddr_i  in  32  APB address; bits [7:0] decoded
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- nonempty_o  out  1  registered, high while FIFO count > 0

Behaviour:
- Reset: FIFO empty, count=0, overflow sticky=0, drop counter=0. All outputs are 0 during and after reset until the first access.
- Reset mid-operation discards all entries immediately (asynchronous).
- APB, zero wait state:
  - pready_o = psel_i & penable_i.
  - prdata_o and pslverr_o are combinational during the access phase and 0 otherwise.
  - Side effects take effect only on the access-phase cycle (psel&penable). The setup phase has no effect.
- Register map, head entry unless noted:
  - 0x00 STATUS (RO): [7:0] count, [8] empty, [9] full, [10] overflow sticky.
  - 0x04 CTRL (WO): bit0 pop, bit1 clear overflow, bit2 flush. Reads of CTRL return 0 with no error.
  - 0x08/0x0C runtime lo/hi; 0x10/0x14 dcache lo/hi; 0x18/0x1C icache lo/hi; 0x20/0x24 sbfull lo/hi (all RO).
  - 0x28 DROPPED (RO): zero-extended drop counter.
  - Counters narrower than 64 bits are zero-extended to 64 bits.
- Reading data registers while empty returns 0 with pslverr_o=0.
- pslverr_o=1 on: an unmapped address, a write to an RO register, or a read of a reserved address. Such accesses have no side effect.
- Push: on snap_valid_i, all four inputs are written at the tail. The entry is readable on the next cycle (count updates next edge).
- Pop: a CTRL write with bit0=1 advances the head next edge. Pop while empty is ignored with no error.
- Simultaneous push and pop:
  - Not full: both happen; count unchanged.
  - Full: pop frees a slot, the push is accepted, no overflow.
- Push when full with no pop: the new snapshot is dropped, overflow sticky set, drop counter +1, saturating at all-ones.
- Flush (bit2): empties the FIFO next edge. It takes priority over a same-cycle pop. A same-cycle push is also discarded.
- CTRL bit1 clears overflow. A same-cycle overflow event wins: the sticky stays 1. The drop counter is cleared only by reset.
- Pointers: log2(Depth)-bit, wrap modulo Depth. Count width is log2(Depth)+1.
- nonempty_o is registered from count: it rises one cycle after the first push and falls the cycle after the last pop.
- Hi/lo coherency: the head entry changes only on pop or flush, so lo and hi reads between pops are consistent.

Optional Feature:
- Macro PERF_SNAP_TIMESTAMP_EN.
- Defined: a free-running 64-bit cycle counter, reset to 0 and incrementing every cycle, is captured with each snapshot into an extra FIFO field. It is readable at 0x30 (lo) and 0x34 (hi).
- Undefined: no counter or storage is built. 0x30/0x34 read 0 with pslverr_o=0.

Test Plan:
- Reset, then read 0x00 → 0x100 (empty=1, count=0); read 0x08 → 0, pslverr_o=0.
- Pulse snap_valid_i with runtime=0x1_0000_0005, dcache=3 → STATUS=0x001, 0x08=0x5, 0x0C=0x1, 0x10=3; nonempty_o=1 the cycle after the push.
- Push 5 snapshots into Depth=4, runtimes 10..14 → STATUS=0x604 (full, overflow); DROPPED=1; pops return runtimes 10, 11, 12, 13, then STATUS=0x500 (empty, overflow still set).
- FIFO full; snap_valid_i in the same cycle as a CTRL pop write → head advances, new entry accepted, count stays 4, overflow stays 0.
- Write 0x38, read 0x40, write 0x00 → pslverr_o=1 on each, state unchanged. CTRL flush with 3 entries → STATUS=0x100 the next cycle.
- With PERF_SNAP_TIMESTAMP_EN: push at cycle N after reset, read 0x30 → N; without the macro, 0x30 → 0.
